cgra_multichain_configurator: RTL and testbench

//  Multi-context, multi-chain successor to the single-chain serial CGRA configurator.
//  A host writes configuration rows into NUM_CONTEXTS on-chip context images.
//  On start, one image is shifted into the fabric, NUM_CHAINS bits per enabled cycle (one bit per chain).

---
 rtl/cgra_cfg_pkg.sv | 20 ++
 rtl/cgra_cfg_crc16.sv | 25 ++
 rtl/cgra_multichain_configurator.sv | 178 +++++++++++++++++
 tb/tb_cgra_multichain_configurator.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cgra_cfg_pkg.sv
// Shared types and constants for the multi-chain CGRA configurator.
// Used by cgra_multichain_configurator and cgra_cfg_crc16.
package cgra_cfg_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} cfg_state_e;

   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   // Index width for n entries (never zero).
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Context ids carry one spare code point so an out-of-range request is expressible.
   function automatic int ctx_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/cgra_cfg_crc16.sv
// Combinational CRC-16-CCITT step over one NUM_CHAINS-bit row, chain 0 bit first.
// Instantiated by the configurator only when CGRA_CFG_CRC_EN is defined.
module cgra_cfg_crc16
   import cgra_cfg_pkg::*;
#(
   parameter int NUM_CHAINS = 4
) (
   input  logic [15:0]           crc_in,
   input  logic [NUM_CHAINS-1:0] data,
   output logic [15:0]           crc_out
);

   logic [15:0] crc_acc;

   always_comb begin
      // NOTE: blocking assignments here are intentional: each bit step feeds the next within one evaluation.
      crc_acc = crc_in;
      for (int i = 0; i < NUM_CHAINS; i++) begin
         if (crc_acc[15] ^ data[i]) crc_acc = {crc_acc[14:0], 1'b0} ^ CRC16_POLY;
         else                       crc_acc = {crc_acc[14:0], 1'b0};
      end
      crc_out = crc_acc;
   end

endmodule

// File: rtl/cgra_multichain_configurator.sv
// Multi-context configurator: stores NUM_CONTEXTS images and shifts one out NUM_CHAINS bits per cycle.
// Optional CRC check of the emitted image is enabled with the CGRA_CFG_CRC_EN macro.
module cgra_multichain_configurator
   import cgra_cfg_pkg::*;
#(
   parameter  int NUM_CHAINS   = 4,
   parameter  int CHAIN_BITS   = 256,
   parameter  int NUM_CONTEXTS = 2,
   localparam int CTX_W        = ctx_w(NUM_CONTEXTS),
   localparam int ADDR_W       = idx_w(CHAIN_BITS)
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [CTX_W-1:0]      wr_ctx,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [NUM_CHAINS-1:0] wr_data,
   input  logic                  start,
   input  logic [CTX_W-1:0]      start_ctx,
   input  logic                  abort,
   input  logic                  enable,
   input  logic [15:0]           crc_expected,
   output logic [NUM_CHAINS-1:0] bitstream,
   output logic                  bitstream_vld,
   output logic                  busy,
   output logic                  done,
   output logic                  cfg_error,
   output logic                  crc_fail
);

   localparam int              MEM_ROWS = NUM_CONTEXTS * CHAIN_BITS;
   localparam int              MEM_AW   = idx_w(MEM_ROWS);
   localparam logic [ADDR_W:0] LAST_POS = (ADDR_W + 1)'(CHAIN_BITS);

   logic [NUM_CHAINS-1:0] mem_q [MEM_ROWS];

   cfg_state_e            state_q, state_d;
   logic [CTX_W-1:0]      ctx_q, ctx_d;
   logic [ADDR_W:0]       pos_q, pos_d;
   logic [NUM_CHAINS-1:0] bitstream_q, bitstream_d;
   logic                  vld_q, vld_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic                  wr_ok, wr_bad, start_ok, start_bad, do_emit, do_finish;
   logic [MEM_AW-1:0]     wr_idx, rd_idx;
   logic [NUM_CHAINS-1:0] rd_row;

   assign wr_ready  = (state_q != SHIFT);
   assign wr_ok     = wr_valid && wr_ready;
   assign wr_bad    = wr_ok && (int'(wr_ctx) >= NUM_CONTEXTS);
   assign start_ok  = start && wr_ready && (int'(start_ctx) < NUM_CONTEXTS);
   assign start_bad = start && wr_ready && (int'(start_ctx) >= NUM_CONTEXTS);

   assign wr_idx = MEM_AW'(int'(wr_ctx) * CHAIN_BITS + int'(wr_addr));
   assign rd_idx = MEM_AW'(int'(ctx_q) * CHAIN_BITS + int'(pos_q[ADDR_W-1:0]));
   assign rd_row = mem_q[rd_idx];

   // NOTE: context images are plain storage without reset so they can map onto RAM.
   always_ff @(posedge clock) begin
      if (wr_ok && !wr_bad) mem_q[wr_idx] <= wr_data;
   end

   always_comb begin
      state_d     = state_q;
      ctx_d       = ctx_q;
      pos_d       = pos_q;
      bitstream_d = bitstream_q;
      vld_d       = 1'b0;
      done_d      = done_q;
      err_d       = err_q;
      do_emit     = 1'b0;
      do_finish   = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (start_ok) begin
               state_d = SHIFT;
               ctx_d   = start_ctx;
               pos_d   = '0;
               done_d  = 1'b0;
               err_d   = 1'b0;
            end else if (start_bad) begin
               err_d = 1'b1;
            end
         end
         SHIFT: begin
            // Abort outranks both completion and a pending enable.
            if (abort) begin
               state_d = IDLE;
            end else if (pos_q == LAST_POS) begin
               state_d     = DONE;
               done_d      = 1'b1;
               bitstream_d = '0;
               do_finish   = 1'b1;
            end else if (enable) begin
               bitstream_d = rd_row;
               vld_d       = 1'b1;
               pos_d       = pos_q + 1'b1;
               do_emit     = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (wr_bad) err_d = 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         ctx_q       <= '0;
         pos_q       <= '0;
         bitstream_q <= '0;
         vld_q       <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ctx_q       <= ctx_d;
         pos_q       <= pos_d;
         bitstream_q <= bitstream_d;
         vld_q       <= vld_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign bitstream     = bitstream_q;
   assign bitstream_vld = vld_q;
   assign busy          = (state_q == SHIFT);
   assign done          = done_q;
   assign cfg_error     = err_q;

`ifdef CGRA_CFG_CRC_EN
   logic [15:0] crc_q, crc_d, crc_next, crc_exp_q, crc_exp_d;
   logic        crc_fail_q, crc_fail_d;

   cgra_cfg_crc16 #(.NUM_CHAINS(NUM_CHAINS)) u_crc16 (
      .crc_in  (crc_q),
      .data    (rd_row),
      .crc_out (crc_next)
   );

   always_comb begin
      crc_d      = crc_q;
      crc_exp_d  = crc_exp_q;
      crc_fail_d = crc_fail_q;
      if (start_ok) begin
         crc_d      = CRC16_INIT;
         crc_exp_d  = crc_expected;
         crc_fail_d = 1'b0;
      end else if (do_emit) begin
         crc_d = crc_next;
      end else if (do_finish) begin
         crc_fail_d = (crc_q != crc_exp_q);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         crc_q      <= CRC16_INIT;
         crc_exp_q  <= '0;
         crc_fail_q <= 1'b0;
      end else begin
         crc_q      <= crc_d;
         crc_exp_q  <= crc_exp_d;
         crc_fail_q <= crc_fail_d;
      end
   end

   assign crc_fail = crc_fail_q;
`else
   logic unused_crc_expected;
   assign unused_crc_expected = ^crc_expected;
   assign crc_fail            = 1'b0;
`endif

endmodule

// File: tb/tb_cgra_multichain_configurator.sv
// Scoreboard bench for cgra_multichain_configurator (4 chains, 8 rows, 2 contexts).
// Expected rows come from a context-image model; a negedge monitor compares emitted rows.
module tb_cgra_multichain_configurator;

   localparam int NC = 4;
   localparam int CB = 8;
   localparam int NX = 2;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [1:0]    wr_ctx = '0;
   logic [2:0]    wr_addr = '0;
   logic [NC-1:0] wr_data = '0;
   logic          start = 1'b0;
   logic [1:0]    start_ctx = '0;
   logic          abort = 1'b0;
   logic          enable = 1'b0;
   logic [15:0]   crc_expected = '0;
   logic [NC-1:0] bitstream;
   logic          bitstream_vld, busy, done, cfg_error, crc_fail;

   cgra_multichain_configurator #(.NUM_CHAINS(NC), .CHAIN_BITS(CB), .NUM_CONTEXTS(NX)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .wr_valid      (wr_valid),
      .wr_ready      (wr_ready),
      .wr_ctx        (wr_ctx),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .start         (start),
      .start_ctx     (start_ctx),
      .abort         (abort),
      .enable        (enable),
      .crc_expected  (crc_expected),
      .bitstream     (bitstream),
      .bitstream_vld (bitstream_vld),
      .busy          (busy),
      .done          (done),
      .cfg_error     (cfg_error),
      .crc_fail      (crc_fail)
   );

   always #5 clock = ~clock;

   int            n_cmp = 0;
   int            n_fail = 0;
   logic [NC-1:0] model_mem [NX][CB];
   logic [NC-1:0] exp_q [$];
   logic          exp_fail = 1'b0;
   int            lat;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Bit-serial CRC-16-CCITT over a whole stored image, row 0 first, chain 0 bit first.
   function automatic logic [15:0] model_crc(input int ctx);
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      for (int r = 0; r < CB; r++) begin
         for (int b = 0; b < NC; b++) begin
            fb = c[15] ^ model_mem[ctx][r][b];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
         end
      end
      return c;
   endfunction

   always @(negedge clock) begin
      if (reset_n && bitstream_vld) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_row: got %0h with no row expected", bitstream);
         end else begin
            check("row", 32'(bitstream), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic write_row(input int ctx, input int addr, input logic [NC-1:0] data);
      wr_valid = 1'b1;
      wr_ctx   = 2'(ctx);
      wr_addr  = 3'(addr);
      wr_data  = data;
      if (ctx < NX) model_mem[ctx][addr] = data;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic start_load(input int ctx, input bit bad_crc);
      start     = 1'b1;
      start_ctx = 2'(ctx);
      if (ctx < NX) begin
         for (int r = 0; r < CB; r++) exp_q.push_back(model_mem[ctx][r]);
`ifdef CGRA_CFG_CRC_EN
         crc_expected = model_crc(ctx) ^ {15'd0, bad_crc};
         exp_fail     = bad_crc;
`else
         crc_expected = 16'($urandom);
         exp_fail     = 1'b0;
`endif
      end
      tick();
      start = 1'b0;
   endtask

   // mode 0: enable held, 1: alternating, 2: random
   task automatic wait_done(input int mode, output int latency);
      latency = -1;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clock);
         if (done) begin
            latency = k;
            break;
         end
         tick();
         if (mode == 1)      enable = ~enable;
         else if (mode == 2) enable = 1'($urandom_range(0, 1));
      end
      if (latency < 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL done_timeout: got no done expected done within 200 cycles");
      end else begin
         check("done_bitstream", 32'(bitstream), 32'h0);
         check("done_vld", 32'(bitstream_vld), 32'h0);
         check("done_busy", 32'(busy), 32'h0);
         check("done_wr_ready", 32'(wr_ready), 32'h1);
         check("queue_drained", 32'(exp_q.size()), 32'h0);
         check("crc_fail", 32'(crc_fail), 32'(exp_fail));
      end
      exp_q.delete();
      tick();
      enable = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Reset state
      @(negedge clock);
      check("rst_bitstream", 32'(bitstream), 32'h0);
      check("rst_vld", 32'(bitstream_vld), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_cfg_error", 32'(cfg_error), 32'h0);
      check("rst_crc_fail", 32'(crc_fail), 32'h0);
      check("rst_wr_ready", 32'(wr_ready), 32'h1);
      @(posedge clock);
      #1 reset_n = 1'b1;
      tick();

      for (int r = 0; r < CB; r++) write_row(1, r, NC'(r));
      for (int r = 0; r < CB; r++) write_row(0, r, NC'($urandom));

      // Continuous enable: exact done latency
      enable = 1'b1;
      start_load(1, 1'b0);
      wait_done(0, lat);
      check("latency_full_enable", 32'(lat), 32'd10);

      // Alternating enable, CRC mismatch requested
      start_load(1, 1'b1);
      wait_done(1, lat);

      // Abort after row 3
      start_load(1, 1'b0);
      repeat (4) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      @(negedge clock);
      check("abort_busy", 32'(busy), 32'h0);
      check("abort_done", 32'(done), 32'h0);
      check("abort_vld", 32'(bitstream_vld), 32'h0);
      check("abort_rows_left", 32'(exp_q.size()), 32'd4);
      exp_q.delete();
      tick();
      start_load(1, 1'b0);
      wait_done(0, lat);
      check("latency_restart", 32'(lat), 32'd10);

      // Bad start context from DONE
      start_load(2, 1'b0);
      @(negedge clock);
      check("bad_start_err", 32'(cfg_error), 32'h1);
      check("bad_start_busy", 32'(busy), 32'h0);
      check("bad_start_done_held", 32'(done), 32'h1);
      tick();
      // Bad write context must not land anywhere
      write_row(3, 2, ~model_mem[1][2]);
      @(negedge clock);
      check("bad_wr_err", 32'(cfg_error), 32'h1);
      tick();
      start_load(1, 1'b0);
      @(negedge clock);
      check("err_cleared", 32'(cfg_error), 32'h0);
      check("restart_busy", 32'(busy), 32'h1);
      check("restart_done_low", 32'(done), 32'h0);
      tick();
      wait_done(2, lat);

      // Write attempted during a shift is refused
      start_load(0, 1'b0);
      tick();
      wr_valid = 1'b1;
      wr_ctx   = 2'd0;
      wr_addr  = 3'd5;
      wr_data  = ~model_mem[0][5];
      @(negedge clock);
      check("shift_wr_ready", 32'(wr_ready), 32'h0);
      tick();
      wr_valid = 1'b0;
      wait_done(0, lat);

      // Reset mid-shift
      start_load(0, 1'b0);
      repeat (3) tick();
      #2 reset_n = 1'b0;
      #1;
      check("midrst_bitstream", 32'(bitstream), 32'h0);
      check("midrst_vld", 32'(bitstream_vld), 32'h0);
      check("midrst_busy", 32'(busy), 32'h0);
      check("midrst_done", 32'(done), 32'h0);
      check("midrst_wr_ready", 32'(wr_ready), 32'h1);
      exp_q.delete();
      tick();
      reset_n = 1'b1;
      @(negedge clock);
      check("postrst_busy", 32'(busy), 32'h0);
      tick();

      // Simultaneous write and start: the write lands before row 0 is read
      wr_valid = 1'b1;
      wr_ctx   = 2'd0;
      wr_addr  = 3'd0;
      wr_data  = ~model_mem[0][0];
      model_mem[0][0] = wr_data;
      start_load(0, 1'b0);
      wr_valid = 1'b0;
      wait_done(0, lat);
      check("latency_wr_start", 32'(lat), 32'd10);

      // Randomized loads
      for (int it = 0; it < 8; it++) begin
         for (int w = 0; w < 3; w++)
            write_row($urandom_range(0, NX - 1), $urandom_range(0, CB - 1), NC'($urandom));
         start_load($urandom_range(0, NX - 1), 1'($urandom_range(0, 1)));
         wait_done(2, lat);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
